// File: rtl/sram_address_pkg.sv
// ---------------------------------------------------------------------------
// sram_address_pkg
// Shared constants, the byte-lane storage type and a parity helper for the
// byte-addressable SRAM word model (sram_address / sram_byte_cell).
//
// Optional feature macro: SRAM_ADDRESS_PARITY_EN adds one even-parity bit per
// stored byte lane.
// ---------------------------------------------------------------------------
package sram_address_pkg;

    localparam int BYTE_W     = 8;
    localparam int DATA_W_DEF = 32;

    // One stored byte lane; carries its parity bit only when parity is built in.
    typedef struct packed {
`ifdef SRAM_ADDRESS_PARITY_EN
        logic              par;
`endif
        logic [BYTE_W-1:0] data;
    } lane_t;

    // Even parity bit: makes the total number of ones (data + bit) even.
    function automatic logic evenParity(input logic [BYTE_W-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/sram_byte_cell.sv
// ---------------------------------------------------------------------------
// sram_byte_cell
// One byte lane of the SRAM word: storage, lane write enable, masked
// registered read and (optionally) per-lane parity.
//
// Optional feature macro: SRAM_ADDRESS_PARITY_EN
//
// Ports
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   wrEn_i    in   accepted write for this word (already qualified by WL)
//   rdEn_i    in   accepted read for this word (already qualified by WL)
//   sel_i     in   this lane's byte_sel bit
//   din_i     in   write data for this lane
//   parInj_i  in   (parity build) invert the parity stored by this write
//   parErr_o  out  (parity build) combinational: selected read sees bad parity
//   dout_o    out  registered read data for this lane
// ---------------------------------------------------------------------------
module sram_byte_cell
    import sram_address_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wrEn_i,
    input  logic              rdEn_i,
    input  logic              sel_i,
    input  logic [BYTE_W-1:0] din_i,
`ifdef SRAM_ADDRESS_PARITY_EN
    input  logic              parInj_i,
    output logic              parErr_o,
`endif
    output logic [BYTE_W-1:0] dout_o
);

    lane_t             lane_q;
    lane_t             lane_d;
    logic [BYTE_W-1:0] dout_q;
    logic [BYTE_W-1:0] dout_d;

    // Next lane contents: only a selected, accepted write replaces the byte
    // (and its parity); everything else keeps what is stored.
    always_comb begin
        lane_d = lane_q;
        if (wrEn_i && sel_i) begin
            lane_d.data = din_i;
`ifdef SRAM_ADDRESS_PARITY_EN
            lane_d.par  = evenParity(din_i) ^ parInj_i;
`endif
        end
    end

    // Next read data: an accepted read returns the stored byte for a selected
    // lane and zero for an unselected one; otherwise the last value is held.
    // Reading lane_q (not lane_d) gives read-before-write on a shared edge.
    always_comb begin
        dout_d = dout_q;
        if (rdEn_i) begin
            dout_d = sel_i ? lane_q.data : '0;
        end
    end

    // Storage and read register, both cleared immediately by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q <= '0;
            dout_q <= '0;
        end else begin
            lane_q <= lane_d;
            dout_q <= dout_d;
        end
    end

`ifdef SRAM_ADDRESS_PARITY_EN
    // Only lanes taking part in the read are checked.
    assign parErr_o = rdEn_i && sel_i && (evenParity(lane_q.data) != lane_q.par);
`endif

    assign dout_o = dout_q;

endmodule

// File: rtl/sram_address.sv
// ---------------------------------------------------------------------------
// sram_address
// Single-word, byte-maskable SRAM model with rising-edge-detected read and
// write requests, read-before-write on simultaneous requests and a one-cycle
// done pulse per accepted request.
//
// Optional feature macro: SRAM_ADDRESS_PARITY_EN (per-lane even parity,
// adds par_inject / par_err).
//
// Ports
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   WL           in   word-line select; requests ignored while 0
//   byte_sel     in   per-lane enable, bit i covers bits [8i+7:8i]
//   read_pulse   in   read request level, acted on at its rising edge
//   write_pulse  in   write request level, acted on at its rising edge
//   datain       in   write data
//   par_inject   in   (parity build) invert parity of lanes being written
//   par_err      out  (parity build) registered parity error, aligned with done
//   dataout      out  registered read data
//   done         out  one-cycle pulse after each accepted request
// ---------------------------------------------------------------------------
module sram_address
    import sram_address_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
)
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     WL,
    input  logic [DATA_W/BYTE_W-1:0] byte_sel,
    input  logic                     read_pulse,
    input  logic                     write_pulse,
    input  logic [DATA_W-1:0]        datain,
`ifdef SRAM_ADDRESS_PARITY_EN
    input  logic                     par_inject,
    output logic                     par_err,
`endif
    output logic [DATA_W-1:0]        dataout,
    output logic                     done
);

    localparam int NB = DATA_W / BYTE_W;

    logic rdPrev_q;
    logic wrPrev_q;
    logic rdArmed_q;
    logic wrArmed_q;
    logic done_q;
    logic rdAcc;
    logic wrAcc;

    // A request is accepted on a 0->1 transition of its level. The armed flags
    // stay clear after reset until the pulse has been seen low, so a pulse
    // that is already high when reset releases does not count as an edge.
    // WL gates the action, not the edge detection: an edge seen with WL=0 is
    // consumed and ignored.
    assign rdAcc = WL && read_pulse  && !rdPrev_q && rdArmed_q;
    assign wrAcc = WL && write_pulse && !wrPrev_q && wrArmed_q;

    // Edge-detect history and the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdPrev_q  <= 1'b0;
            wrPrev_q  <= 1'b0;
            rdArmed_q <= 1'b0;
            wrArmed_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            rdPrev_q  <= read_pulse;
            wrPrev_q  <= write_pulse;
            rdArmed_q <= rdArmed_q || !read_pulse;
            wrArmed_q <= wrArmed_q || !write_pulse;
            done_q    <= rdAcc || wrAcc;
        end
    end

`ifdef SRAM_ADDRESS_PARITY_EN
    logic [NB-1:0] laneErr;
    logic          parErr_q;

    // Parity error flag shares done's timing: set for the cycle after an
    // accepted read whose selected lanes hold a bad parity bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parErr_q <= 1'b0;
        end else begin
            parErr_q <= rdAcc && (|laneErr);
        end
    end

    assign par_err = parErr_q;
`endif

    genvar g;
    generate
        for (g = 0; g < NB; g++) begin : gLane
            sram_byte_cell uCell (
                .clk      (clk),
                .rst_n    (rst_n),
                .wrEn_i   (wrAcc),
                .rdEn_i   (rdAcc),
                .sel_i    (byte_sel[g]),
                .din_i    (datain[g*BYTE_W +: BYTE_W]),
`ifdef SRAM_ADDRESS_PARITY_EN
                .parInj_i (par_inject),
                .parErr_o (laneErr[g]),
`endif
                .dout_o   (dataout[g*BYTE_W +: BYTE_W])
            );
        end
    endgenerate

    assign done = done_q;

endmodule

// File: tb/tb_sram_address.sv
// ---------------------------------------------------------------------------
// tb_sram_address
// Directed bench for sram_address (DATA_W=32). A byte-array model of the
// word tracks what dataout/done (and par_err in the parity build) must be on
// every cycle; literal expectations at key points pin the model.
// Optional feature macro: SRAM_ADDRESS_PARITY_EN
// ---------------------------------------------------------------------------
module tb_sram_address;

    localparam int NB = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        WL;
    logic [3:0]  byte_sel;
    logic        read_pulse;
    logic        write_pulse;
    logic [31:0] datain;
    logic [31:0] dataout;
    logic        done;
`ifdef SRAM_ADDRESS_PARITY_EN
    logic        par_inject;
    logic        par_err;
`endif

    int compared   = 0;
    int mismatched = 0;

    sram_address #(.DATA_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .WL          (WL),
        .byte_sel    (byte_sel),
        .read_pulse  (read_pulse),
        .write_pulse (write_pulse),
        .datain      (datain),
`ifdef SRAM_ADDRESS_PARITY_EN
        .par_inject  (par_inject),
        .par_err     (par_err),
`endif
        .dataout     (dataout),
        .done        (done)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    // Model state: the word as four bytes, expected outputs, and the last
    // sampled level of each pulse (-1 means "not sampled since reset").
    logic [7:0]  mMem [NB];
    logic [31:0] expOut    = '0;
    logic        expDone   = 1'b0;
    int          prevRd    = -1;
    int          prevWr    = -1;
`ifdef SRAM_ADDRESS_PARITY_EN
    logic        mPar [NB];
    logic        expParErr = 1'b0;
`endif

    // Behavioural model: at each clock edge decide which requests were
    // accepted, read the old bytes, then apply the masked write.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NB; i++) begin
                mMem[i] <= 8'h00;
`ifdef SRAM_ADDRESS_PARITY_EN
                mPar[i] <= 1'b0;
`endif
            end
            expOut  <= '0;
            expDone <= 1'b0;
            prevRd  <= -1;
            prevWr  <= -1;
`ifdef SRAM_ADDRESS_PARITY_EN
            expParErr <= 1'b0;
`endif
        end else begin
            automatic bit rdGo = (read_pulse  === 1'b1) && (prevRd == 0) && (WL === 1'b1);
            automatic bit wrGo = (write_pulse === 1'b1) && (prevWr == 0) && (WL === 1'b1);
            automatic logic [31:0] rdWord = '0;
            automatic bit anyBad = 1'b0;
            prevRd  <= (read_pulse  === 1'b1) ? 1 : 0;
            prevWr  <= (write_pulse === 1'b1) ? 1 : 0;
            expDone <= rdGo || wrGo;
            if (rdGo) begin
                for (int i = 0; i < NB; i++) begin
                    if (byte_sel[i]) begin
                        rdWord[i*8 +: 8] = mMem[i];
`ifdef SRAM_ADDRESS_PARITY_EN
                        if ((^mMem[i]) != mPar[i]) anyBad = 1'b1;
`endif
                    end
                end
                expOut <= rdWord;
            end
`ifdef SRAM_ADDRESS_PARITY_EN
            expParErr <= rdGo && anyBad;
`endif
            if (wrGo) begin
                for (int i = 0; i < NB; i++) begin
                    if (byte_sel[i]) begin
                        mMem[i] <= datain[i*8 +: 8];
`ifdef SRAM_ADDRESS_PARITY_EN
                        mPar[i] <= (^datain[i*8 +: 8]) ^ par_inject;
`endif
                    end
                end
            end
        end
    end

    // One comparison of a DUT value against its expected value.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one set of inputs just after a falling edge.
    task automatic applyStimulus(input logic wl, input logic [3:0] sel,
                                 input logic rd, input logic wr, input logic [31:0] din);
        @(negedge clk);
        WL          = wl;
        byte_sel    = sel;
        read_pulse  = rd;
        write_pulse = wr;
        datain      = din;
    endtask

    // Step past the next rising edge so registered outputs have settled.
    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    // Cycle-by-cycle comparison of the DUT against the model.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            checkOutput("cycDataout", dataout, expOut);
            checkOutput("cycDone", {31'b0, done}, {31'b0, expDone});
`ifdef SRAM_ADDRESS_PARITY_EN
            checkOutput("cycParErr", {31'b0, par_err}, {31'b0, expParErr});
`endif
        end
    end

    // Directed stimulus with literal expectations.
    initial begin
        rst_n       = 1'b0;
        WL          = 1'b0;
        byte_sel    = 4'h0;
        read_pulse  = 1'b0;
        write_pulse = 1'b0;
        datain      = '0;
`ifdef SRAM_ADDRESS_PARITY_EN
        par_inject  = 1'b0;
`endif
        #1;
        checkOutput("rstDataout", dataout, 32'h0);
        checkOutput("rstDone", {31'b0, done}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        $display("[TB] reset released");

        applyStimulus(1'b1, 4'hF, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 4'hF, 1'b0, 1'b1, 32'hDEADBEEF);
        settle();
        checkOutput("wrFullDone", {31'b0, done}, 32'h1);
        applyStimulus(1'b1, 4'hF, 1'b0, 1'b0, 32'h0);
        settle();
        checkOutput("wrFullDoneOff", {31'b0, done}, 32'h0);
        applyStimulus(1'b1, 4'hF, 1'b1, 1'b0, 32'h0);
        settle();
        checkOutput("rdFull", dataout, 32'hDEADBEEF);
        checkOutput("rdFullDone", {31'b0, done}, 32'h1);
        applyStimulus(1'b1, 4'hF, 1'b0, 1'b0, 32'h0);

        applyStimulus(1'b1, 4'h5, 1'b0, 1'b1, 32'h11223344);
        applyStimulus(1'b1, 4'h5, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 4'hF, 1'b1, 1'b0, 32'h0);
        settle();
        checkOutput("rdMerged", dataout, 32'hDE22BE44);
        applyStimulus(1'b1, 4'hF, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 4'h2, 1'b1, 1'b0, 32'h0);
        settle();
        checkOutput("rdLane1", dataout, 32'h0000BE00);
        applyStimulus(1'b1, 4'h2, 1'b0, 1'b0, 32'h0);

        applyStimulus(1'b0, 4'hF, 1'b0, 1'b1, 32'hFFFFFFFF);
        settle();
        checkOutput("wl0Done", {31'b0, done}, 32'h0);
        checkOutput("wl0Hold", dataout, 32'h0000BE00);
        applyStimulus(1'b0, 4'hF, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 4'hF, 1'b1, 1'b0, 32'h0);
        settle();
        checkOutput("rdAfterWl0", dataout, 32'hDE22BE44);
        applyStimulus(1'b1, 4'hF, 1'b0, 1'b0, 32'h0);

        applyStimulus(1'b1, 4'hF, 1'b1, 1'b1, 32'hCAFEF00D);
        settle();
        checkOutput("rbwOld", dataout, 32'hDE22BE44);
        checkOutput("rbwDone", {31'b0, done}, 32'h1);
        applyStimulus(1'b1, 4'hF, 1'b0, 1'b0, 32'h0);
        settle();
        checkOutput("rbwDoneOff", {31'b0, done}, 32'h0);
        applyStimulus(1'b1, 4'hF, 1'b1, 1'b0, 32'h0);
        settle();
        checkOutput("rbwNew", dataout, 32'hCAFEF00D);
        applyStimulus(1'b1, 4'hF, 1'b0, 1'b0, 32'h0);

        applyStimulus(1'b1, 4'hF, 1'b0, 1'b1, 32'h12345678);
        settle();
        checkOutput("holdFirstDone", {31'b0, done}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            settle();
            checkOutput("holdNoDone", {31'b0, done}, 32'h0);
        end
        applyStimulus(1'b1, 4'hF, 1'b1, 1'b1, 32'h12345678);
        settle();
        checkOutput("holdRead", dataout, 32'h12345678);
        applyStimulus(1'b1, 4'hF, 1'b0, 1'b1, 32'h55AA55AA);
        settle();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midRstDataout", dataout, 32'h0);
        checkOutput("midRstDone", {31'b0, done}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        settle();
        checkOutput("relNoDone", {31'b0, done}, 32'h0);
        settle();
        checkOutput("relNoDone2", {31'b0, done}, 32'h0);
        applyStimulus(1'b1, 4'hF, 1'b1, 1'b1, 32'h55AA55AA);
        settle();
        checkOutput("relStorage", dataout, 32'h0);
        checkOutput("relReadDone", {31'b0, done}, 32'h1);
        applyStimulus(1'b1, 4'hF, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 4'hF, 1'b0, 1'b1, 32'h55AA55AA);
        settle();
        checkOutput("rearmDone", {31'b0, done}, 32'h1);
        applyStimulus(1'b1, 4'hF, 1'b1, 1'b0, 32'h0);
        settle();
        checkOutput("rearmRead", dataout, 32'h55AA55AA);
        applyStimulus(1'b1, 4'hF, 1'b0, 1'b0, 32'h0);

        applyStimulus(1'b1, 4'h0, 1'b1, 1'b1, 32'hFFFFFFFF);
        settle();
        checkOutput("sel0Read", dataout, 32'h0);
        checkOutput("sel0Done", {31'b0, done}, 32'h1);
        applyStimulus(1'b1, 4'h0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 4'hF, 1'b1, 1'b0, 32'h0);
        settle();
        checkOutput("sel0NoWrite", dataout, 32'h55AA55AA);
        applyStimulus(1'b1, 4'hF, 1'b0, 1'b0, 32'h0);

`ifdef SRAM_ADDRESS_PARITY_EN
        @(negedge clk);
        par_inject = 1'b1;
        applyStimulus(1'b1, 4'h1, 1'b0, 1'b1, 32'h000000A5);
        @(negedge clk);
        par_inject  = 1'b0;
        write_pulse = 1'b0;
        applyStimulus(1'b1, 4'h1, 1'b1, 1'b0, 32'h0);
        settle();
        checkOutput("parErrSet", {31'b0, par_err}, 32'h1);
        checkOutput("parRead", dataout, 32'h000000A5);
        applyStimulus(1'b1, 4'h1, 1'b0, 1'b0, 32'h0);
        settle();
        checkOutput("parErrClear", {31'b0, par_err}, 32'h0);
        applyStimulus(1'b1, 4'h2, 1'b1, 1'b0, 32'h0);
        settle();
        checkOutput("parErrUnsel", {31'b0, par_err}, 32'h0);
        checkOutput("parUnselRead", dataout, 32'h00005500);
        applyStimulus(1'b1, 4'h2, 1'b0, 1'b0, 32'h0);
`endif

        repeat (3) @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sram_address.md
SRAM_ADDRESS -- requirements
Module: sram_address

Interface
REQ-001 Parameter: DATA_W, default 32, word width in bits; SHALL be a multiple of 8 (NB = DATA_W/8 byte lanes).
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: WL  input  1  word-line select; row enabled when 1.
REQ-005 Port: byte_sel  input  NB  per-byte lane enable, bit i selects bits [8i+7:8i].
REQ-006 Port: read_pulse  input  1  read request, level signal, acted on at its rising edge.
REQ-007 Port: write_pulse  input  1  write request, level signal, acted on at its rising edge.
REQ-008 Port: datain  input  DATA_W  write data.
REQ-009 Port: dataout  output  DATA_W  registered read data.
REQ-010 Port: done  output  1  one-cycle pulse, one per accepted read or write.

Function
REQ-011 Rising-edge detect: a request SHALL be accepted on the clk edge where the sampled pulse is 1 and its previous sampled value was 0; a held-high pulse SHALL act only once.
REQ-012 Accepted write with WL=1: each lane i with byte_sel[i]=1 SHALL store datain lane i at that edge; unselected lanes SHALL keep their contents.
REQ-013 Accepted read with WL=1: at that edge dataout lane i SHALL load stored lane i if byte_sel[i]=1, else 8'h00.
REQ-014 dataout SHALL hold its value between accepted reads, including while WL=0.
REQ-015 Requests with WL=0 SHALL be ignored: no storage change, no dataout change, no done.
REQ-016 Simultaneous accepted read and write: both SHALL be performed on the same edge; dataout SHALL return pre-write contents (read-before-write).
REQ-017 done SHALL be 1 for exactly the cycle after any accepted request with WL=1, then 0.
REQ-018 byte_sel=0 with an accepted request SHALL still assert done; a write changes nothing, a read drives dataout to 0.
REQ-019 Latency: storage and dataout update at the accepting edge (0 extra cycles); done follows one cycle later.

Reset
REQ-020 While rst_n=0: all storage lanes, dataout, done and edge-detect history SHALL be 0 immediately, independent of clk.
REQ-021 A pulse already high when rst_n deasserts SHALL NOT be treated as a rising edge until it returns low and rises again.
REQ-022 Reset asserted mid-operation SHALL abort it; no partial lane update survives reset.

Configuration
REQ-023 Macro SRAM_ADDRESS_PARITY_EN: when defined, the module SHALL store one even-parity bit per lane and add ports par_inject (input 1, inverts the stored parity of lanes written while it is 1) and par_err (output 1, registered).
REQ-024 With SRAM_ADDRESS_PARITY_EN, an accepted read SHALL set par_err=1 for one cycle (aligned with done) if any selected lane's recomputed parity mismatches; unselected lanes are not checked; par_err resets to 0.
REQ-025 Without SRAM_ADDRESS_PARITY_EN, no parity storage, par_inject or par_err SHALL exist; behaviour otherwise identical.

Structure
REQ-026 Package sram_address_pkg SHALL hold BYTE_W=8, the DATA_W default, and a byte-lane typedef (8-bit data plus optional parity bit).
REQ-027 Sub-module sram_byte_cell SHALL implement one lane (storage, write enable, masked read, parity under the macro); sram_address SHALL instantiate NB of them via generate.

Verification
REQ-028 Reset, then WL=1, byte_sel=4'hF, write 32'hDEADBEEF, read -> dataout=32'hDEADBEEF, done pulsed once per request.
REQ-029 Write 32'h11223344 with byte_sel=4'h5, read with byte_sel=4'hF -> dataout=32'hDE22BE44; read with byte_sel=4'h2 -> 32'h0000BE00.
REQ-030 WL=0, write 32'hFFFFFFFF, then WL=1 full read -> contents unchanged (32'hDE22BE44); no done during WL=0 request.
REQ-031 read_pulse and write_pulse rise together, write 32'hCAFEF00D full mask -> dataout=old contents; next read -> 32'hCAFEF00D.
REQ-032 write_pulse held high 5 cycles -> one write, one done; assert rst_n=0 mid-hold -> dataout=0 and storage=0 at once; no write on release.
REQ-033 With SRAM_ADDRESS_PARITY_EN: write 32'h000000A5 lane 0 with par_inject=1, read byte_sel=4'h1 -> par_err=1 one cycle; read byte_sel=4'h2 -> par_err=0.
